sync_fifo_param: RTL and testbench



---
 rtl/sync_fifo_pkg.sv | 44 ++++
 rtl/fifo_mem.sv | 39 +++
 rtl/sync_fifo_param_chk.sv | 36 +++
 rtl/sync_fifo_param.sv | 182 ++++++++++++++++++
 tb/tb_sync_fifo_param.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared constants and helper functions for the parametrised synchronous FIFO:
//   calc_cw       : width of the fill counter, able to hold 0..DEPTH
//   calc_pw       : width of a read/write pointer, at least 1 bit
//   next_ptr      : pointer increment with an explicit wrap at DEPTH-1
//   *_ok          : parameter range checks used at elaboration time
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

   function automatic int calc_cw(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int calc_pw(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

   // Wrap is explicit so non-power-of-two depths never index past the array.
   function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
      return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
   endfunction

   function automatic bit width_ok(input int width);
      return (width >= 1);
   endfunction

   function automatic bit depth_ok(input int depth);
      return (depth >= 2);
   endfunction

   function automatic bit afull_th_ok(input int th, input int depth);
      return (th >= 1) && (th <= depth);
   endfunction

   function automatic bit aempty_th_ok(input int th, input int depth);
      return (th >= 0) && (th <= depth - 1);
   endfunction

   function automatic bit fwft_ok(input int fwft);
      return (fwft == 0) || (fwft == 1);
   endfunction

endpackage : sync_fifo_pkg

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// WIDTH x DEPTH simple dual-port storage: synchronous write, asynchronous read.
// Contents are deliberately not reset.
// Ports:
//   clk   : write clock
//   we    : write enable
//   waddr : write address (0..DEPTH-1)
//   wdata : write data
//   raddr : read address (0..DEPTH-1)
//   rdata : combinational read data at raddr
// -----------------------------------------------------------------------------
module fifo_mem
   import sync_fifo_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int PW    = calc_pw(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [PW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [PW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Storage array write port.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule : fifo_mem

// File: rtl/sync_fifo_param_chk.sv
// -----------------------------------------------------------------------------
// sync_fifo_param_chk
// Elaboration-time parameter checks for sync_fifo_param. Holds no logic and
// has no ports; an illegal parameter set stops elaboration with a message.
// -----------------------------------------------------------------------------
module sync_fifo_param_chk
   import sync_fifo_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 4,
   parameter int AFULL_TH  = DEPTH - 1,
   parameter int AEMPTY_TH = 1,
   parameter int FWFT      = 0
) ();

   if (!width_ok(WIDTH)) begin : g_bad_width
      $error("sync_fifo_param: WIDTH must be >= 1");
   end

   if (!depth_ok(DEPTH)) begin : g_bad_depth
      $error("sync_fifo_param: DEPTH must be >= 2");
   end

   if (!afull_th_ok(AFULL_TH, DEPTH)) begin : g_bad_afull
      $error("sync_fifo_param: AFULL_TH must be in 1..DEPTH");
   end

   if (!aempty_th_ok(AEMPTY_TH, DEPTH)) begin : g_bad_aempty
      $error("sync_fifo_param: AEMPTY_TH must be in 0..DEPTH-1");
   end

   if (!fwft_ok(FWFT)) begin : g_bad_fwft
      $error("sync_fifo_param: FWFT must be 0 or 1");
   end

endmodule : sync_fifo_param_chk

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Single-clock parametrised FIFO with exact fill count, programmable
// almost-full / almost-empty thresholds, FWFT or registered-read mode,
// synchronous flush and sticky overflow / underflow flags.
// Ports:
//   clk          : clock, rising edge
//   rst          : asynchronous active-high reset
//   din, wr_en   : write data / write request
//   rd_en        : read request (FWFT=1: acknowledge of the word on dout)
//   flush        : synchronous clear of contents (pointers and count)
//   clr_err      : synchronous clear of the sticky error flags
//   dout         : read data
//   full, empty, almost_full, almost_empty : status, decoded from count
//   count        : number of entries held (0..DEPTH)
//   overflow     : sticky, write attempted while full
//   underflow    : sticky, read attempted while empty
// -----------------------------------------------------------------------------
module sync_fifo_param
   import sync_fifo_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 4,
   parameter int AFULL_TH  = DEPTH - 1,
   parameter int AEMPTY_TH = 1,
   parameter int FWFT      = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [WIDTH-1:0]          din,
   input  logic                      wr_en,
   input  logic                      rd_en,
   input  logic                      flush,
   input  logic                      clr_err,
   output logic [WIDTH-1:0]          dout,
   output logic                      full,
   output logic                      empty,
   output logic                      almost_full,
   output logic                      almost_empty,
   output logic [calc_cw(DEPTH)-1:0] count,
   output logic                      overflow,
   output logic                      underflow
);

   localparam int CW = calc_cw(DEPTH);
   localparam int PW = calc_pw(DEPTH);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_C = CW'(AFULL_TH);
   localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);
   localparam logic [CW-1:0] ONE_C   = CW'(1'b1);
   localparam logic [CW-1:0] ZERO_C  = CW'(1'b0);

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             afull_q, afull_d;
   logic             aempty_q, aempty_d;

   logic             wr_acc_s;
   logic             rd_acc_s;
   logic [WIDTH-1:0] mem_rdata_s;

   sync_fifo_param_chk #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .AFULL_TH  (AFULL_TH),
      .AEMPTY_TH (AEMPTY_TH),
      .FWFT      (FWFT)
   ) u_chk ();

   fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .PW    (PW)
   ) u_mem (
      .clk   (clk),
      .we    (wr_acc_s),
      .waddr (wr_ptr_q),
      .wdata (din),
      .raddr (rd_ptr_q),
      .rdata (mem_rdata_s)
   );

   // Accept decisions from registered flags; flush suppresses both sides.
   always_comb begin
      wr_acc_s = wr_en & ~full_q & ~flush;
      rd_acc_s = rd_en & ~empty_q & ~flush;
   end

   // Next-state for pointers, count, read register and sticky errors.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      dout_d   = dout_q;

      if (flush) begin
         wr_ptr_d = {PW{1'b0}};
         rd_ptr_d = {PW{1'b0}};
         count_d  = ZERO_C;
      end else begin
         if (wr_acc_s) begin
            wr_ptr_d = PW'(next_ptr(32'(wr_ptr_q), 32'(DEPTH)));
         end else begin
            wr_ptr_d = wr_ptr_q;
         end

         if (rd_acc_s) begin
            rd_ptr_d = PW'(next_ptr(32'(rd_ptr_q), 32'(DEPTH)));
         end else begin
            rd_ptr_d = rd_ptr_q;
         end

         case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
         endcase
      end

      // Registered-read data only moves on an accepted read.
      if (rd_acc_s && (FWFT == 0)) begin
         dout_d = mem_rdata_s;
      end else begin
         dout_d = dout_q;
      end

      // A set in the same cycle as clr_err wins; flush never sets errors.
      overflow_d  = (overflow_q  & ~clr_err) | (wr_en & full_q  & ~flush);
      underflow_d = (underflow_q & ~clr_err) | (rd_en & empty_q & ~flush);

      // Flags are precomputed from the next count so they leave a flop.
      full_d   = (count_d == DEPTH_C);
      empty_d  = (count_d == ZERO_C);
      afull_d  = (count_d >= AFULL_C);
      aempty_d = (count_d <= AEMPTY_C);
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= {PW{1'b0}};
         rd_ptr_q    <= {PW{1'b0}};
         count_q     <= ZERO_C;
         dout_q      <= {WIDTH{1'b0}};
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         afull_q     <= 1'b0;
         aempty_q    <= 1'b1;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         dout_q      <= dout_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         full_q      <= full_d;
         empty_q     <= empty_d;
         afull_q     <= afull_d;
         aempty_q    <= aempty_d;
      end
   end

   // In FWFT mode the head word is shown straight from storage.
   assign dout         = (FWFT != 0) ? mem_rdata_s : dout_q;
   assign full         = full_q;
   assign empty        = empty_q;
   assign almost_full  = afull_q;
   assign almost_empty = aempty_q;
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

endmodule : sync_fifo_param

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
// Three FIFO instances share one stimulus stream:
//   u0 : DEPTH=4, AFULL_TH=3, AEMPTY_TH=1, registered read
//   u1 : DEPTH=5, AFULL_TH=4, AEMPTY_TH=1, registered read
//   u2 : DEPTH=4, AFULL_TH=3, AEMPTY_TH=1, FWFT
// The reference model keeps each FIFO as an ordered list of words.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] din;
   logic       wr_en, rd_en, flush, clr_err;

   logic [7:0] o_dout  [3];
   logic [2:0] o_cnt   [3];
   logic       o_full  [3];
   logic       o_empty [3];
   logic       o_af    [3];
   logic       o_ae    [3];
   logic       o_ovf   [3];
   logic       o_udf   [3];

   int n_cmp = 0;
   int n_err = 0;

   // model state
   int         md  [3] = '{4, 5, 4};
   int         mfw [3] = '{0, 0, 1};
   int         maf [3] = '{3, 4, 3};
   int         mae [3] = '{1, 1, 1};
   logic [7:0] mbuf [3][8];
   int         mlen [3];
   bit         movf [3];
   bit         mudf [3];
   logic [7:0] mdout [3];

   always #5 clk = ~clk;

   sync_fifo_param #(.WIDTH(8), .DEPTH(4), .AFULL_TH(3), .AEMPTY_TH(1), .FWFT(0)) u0 (
      .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en), .flush(flush),
      .clr_err(clr_err), .dout(o_dout[0]), .full(o_full[0]), .empty(o_empty[0]),
      .almost_full(o_af[0]), .almost_empty(o_ae[0]), .count(o_cnt[0]),
      .overflow(o_ovf[0]), .underflow(o_udf[0]));

   sync_fifo_param #(.WIDTH(8), .DEPTH(5), .AFULL_TH(4), .AEMPTY_TH(1), .FWFT(0)) u1 (
      .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en), .flush(flush),
      .clr_err(clr_err), .dout(o_dout[1]), .full(o_full[1]), .empty(o_empty[1]),
      .almost_full(o_af[1]), .almost_empty(o_ae[1]), .count(o_cnt[1]),
      .overflow(o_ovf[1]), .underflow(o_udf[1]));

   sync_fifo_param #(.WIDTH(8), .DEPTH(4), .AFULL_TH(3), .AEMPTY_TH(1), .FWFT(1)) u2 (
      .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en), .flush(flush),
      .clr_err(clr_err), .dout(o_dout[2]), .full(o_full[2]), .empty(o_empty[2]),
      .almost_full(o_af[2]), .almost_empty(o_ae[2]), .count(o_cnt[2]),
      .overflow(o_ovf[2]), .underflow(o_udf[2]));

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         mlen[i]  = 0;
         movf[i]  = 1'b0;
         mudf[i]  = 1'b0;
         mdout[i] = 8'h00;
      end
   endtask

   task automatic model_step(input logic w, input logic r, input logic f,
                             input logic c, input logic [7:0] d);
      for (int i = 0; i < 3; i++) begin
         bit was_full, was_empty, nov, nud;
         was_full  = (mlen[i] == md[i]);
         was_empty = (mlen[i] == 0);
         if (f) begin
            mlen[i] = 0;
            if (c) begin
               movf[i] = 1'b0;
               mudf[i] = 1'b0;
            end
         end else begin
            nov = (movf[i] && !c) || (w && was_full);
            nud = (mudf[i] && !c) || (r && was_empty);
            if (r && !was_empty) begin
               if (mfw[i] == 0) mdout[i] = mbuf[i][0];
               for (int k = 0; k < 7; k++) mbuf[i][k] = mbuf[i][k+1];
               mlen[i] = mlen[i] - 1;
            end
            if (w && !was_full) begin
               mbuf[i][mlen[i]] = d;
               mlen[i] = mlen[i] + 1;
            end
            movf[i] = nov;
            mudf[i] = nud;
         end
      end
   endtask

   // One clock of stimulus; outputs are sampled 1 time unit after the edge.
   task automatic step(input logic w, input logic r, input logic f,
                       input logic c, input logic [7:0] d);
      wr_en = w; rd_en = r; flush = f; clr_err = c; din = d;
      model_step(w, r, f, c, d);
      @(posedge clk);
      #1;
      wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
   endtask

   task automatic test_reset();
      n_cmp++;
      if (o_cnt[0] !== 3'd0) begin
         n_err++; $display("FAIL reset_count: got %0d expected 0", o_cnt[0]);
      end
      n_cmp++;
      if ({o_full[0], o_empty[0], o_af[0], o_ae[0]} !== 4'b0101) begin
         n_err++; $display("FAIL reset_flags: got %b expected 0101",
                           {o_full[0], o_empty[0], o_af[0], o_ae[0]});
      end
      n_cmp++;
      if (o_dout[0] !== 8'h00) begin
         n_err++; $display("FAIL reset_dout: got %h expected 00", o_dout[0]);
      end
      n_cmp++;
      if ({o_ovf[0], o_udf[0]} !== 2'b00) begin
         n_err++; $display("FAIL reset_err: got %b expected 00", {o_ovf[0], o_udf[0]});
      end
   endtask

   task automatic test_fill_and_order();
      logic [7:0] wd [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      logic       exp_ae [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
      logic       exp_af [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0, wd[k]);
         n_cmp++;
         if ({o_af[0], o_ae[0]} !== {exp_af[k], exp_ae[k]}) begin
            n_err++; $display("FAIL fill_thresh[%0d]: got af/ae %b expected %b", k,
                              {o_af[0], o_ae[0]}, {exp_af[k], exp_ae[k]});
         end
      end
      n_cmp++;
      if ({o_full[0], o_cnt[0]} !== {1'b1, 3'd4}) begin
         n_err++; $display("FAIL fill_full: got full=%b count=%0d expected full=1 count=4",
                           o_full[0], o_cnt[0]);
      end
      n_cmp++;
      if (o_dout[2] !== 8'h11) begin
         n_err++; $display("FAIL fwft_head: got %h expected 11", o_dout[2]);
      end
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h55);
      n_cmp++;
      if ({o_ovf[0], o_cnt[0]} !== {1'b1, 3'd4}) begin
         n_err++; $display("FAIL overflow: got ovf=%b count=%0d expected ovf=1 count=4",
                           o_ovf[0], o_cnt[0]);
      end
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
         n_cmp++;
         if (o_dout[0] !== wd[k]) begin
            n_err++; $display("FAIL read_order[%0d]: got %h expected %h", k, o_dout[0], wd[k]);
         end
      end
      n_cmp++;
      if (o_empty[0] !== 1'b1) begin
         n_err++; $display("FAIL drained_empty: got %b expected 1", o_empty[0]);
      end
   endtask

   task automatic test_read_latency();
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'hA5);
      n_cmp++;
      if (o_dout[0] !== 8'h44) begin
         n_err++; $display("FAIL dout_hold_pre_read: got %h expected 44", o_dout[0]);
      end
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      n_cmp++;
      if ({o_dout[0], o_empty[0], o_cnt[0]} !== {8'hA5, 1'b1, 3'd0}) begin
         n_err++; $display("FAIL read_latency: got dout=%h empty=%b count=%0d expected A5/1/0",
                           o_dout[0], o_empty[0], o_cnt[0]);
      end
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      n_cmp++;
      if ({o_udf[0], o_dout[0]} !== {1'b1, 8'hA5}) begin
         n_err++; $display("FAIL underflow: got udf=%b dout=%h expected 1/A5",
                           o_udf[0], o_dout[0]);
      end
   endtask

   task automatic test_boundary();
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h61 + k));
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h65);
      n_cmp++;
      if ({o_cnt[0], o_ovf[0], o_dout[0]} !== {3'd3, 1'b1, 8'h61}) begin
         n_err++; $display("FAIL full_both: got count=%0d ovf=%b dout=%h expected 3/1/61",
                           o_cnt[0], o_ovf[0], o_dout[0]);
      end
      for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h5A);
      n_cmp++;
      if ({o_cnt[0], o_udf[0]} !== {3'd1, 1'b1}) begin
         n_err++; $display("FAIL empty_both: got count=%0d udf=%b expected 1/1",
                           o_cnt[0], o_udf[0]);
      end
      n_cmp++;
      if (o_dout[2] !== 8'h5A) begin
         n_err++; $display("FAIL fwft_next_cycle: got %h expected 5A", o_dout[2]);
      end
   endtask

   task automatic test_flush();
      for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h71 + k));
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h74);
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b0, 1'b1, 1'b0, 8'h99);
      n_cmp++;
      if ({o_cnt[0], o_empty[0], o_ovf[0], o_dout[0]} !== {3'd0, 1'b1, 1'b1, 8'h5A}) begin
         n_err++; $display("FAIL flush: got count=%0d empty=%b ovf=%b dout=%h expected 0/1/1/5A",
                           o_cnt[0], o_empty[0], o_ovf[0], o_dout[0]);
      end
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      n_cmp++;
      if ({o_ovf[0], o_udf[0]} !== 2'b00) begin
         n_err++; $display("FAIL clr_err: got %b expected 00", {o_ovf[0], o_udf[0]});
      end
   endtask

   task automatic test_steady_wrap();
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'($urandom));
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'($urandom));
      for (int n = 0; n < 20; n++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0, 8'($urandom));
         for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (o_cnt[i] !== 3'd2) begin
               n_err++; $display("FAIL steady_count u%0d cyc%0d: got %0d expected 2",
                                 i, n, o_cnt[i]);
            end
            n_cmp++;
            if (o_dout[i] !== ((mfw[i] != 0) ? mbuf[i][0] : mdout[i])) begin
               n_err++; $display("FAIL steady_data u%0d cyc%0d: got %h expected %h", i, n,
                                 o_dout[i], (mfw[i] != 0) ? mbuf[i][0] : mdout[i]);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'hC0 + k));
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({o_cnt[0], o_empty[0], o_full[0], o_dout[0], o_ovf[0], o_udf[0]} !==
          {3'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
         n_err++; $display("FAIL async_reset: got count=%0d empty=%b full=%b dout=%h ovf=%b udf=%b",
                           o_cnt[0], o_empty[0], o_full[0], o_dout[0], o_ovf[0], o_udf[0]);
      end
      n_cmp++;
      if ({o_cnt[1], o_empty[1], o_cnt[2], o_empty[2]} !== {3'd0, 1'b1, 3'd0, 1'b1}) begin
         n_err++; $display("FAIL async_reset_others: got %0d/%b %0d/%b expected 0/1 0/1",
                           o_cnt[1], o_empty[1], o_cnt[2], o_empty[2]);
      end
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h77);
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h88);
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      n_cmp++;
      if (o_dout[0] !== 8'h77) begin
         n_err++; $display("FAIL post_reset_first: got %h expected 77", o_dout[0]);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         logic w, r, f, c;
         w = ($urandom_range(0, 99) < 55);
         r = ($urandom_range(0, 99) < 50);
         f = ($urandom_range(0, 99) < 3);
         c = ($urandom_range(0, 99) < 5);
         step(w, r, f, c, 8'($urandom));
         for (int i = 0; i < 3; i++) begin
            logic [5:0] ef, of;
            ef = {mlen[i] == md[i], mlen[i] == 0, mlen[i] >= maf[i], mlen[i] <= mae[i],
                  movf[i], mudf[i]};
            of = {o_full[i], o_empty[i], o_af[i], o_ae[i], o_ovf[i], o_udf[i]};
            n_cmp++;
            if (o_cnt[i] !== 3'(mlen[i])) begin
               n_err++; $display("FAIL rand_count u%0d cyc%0d: got %0d expected %0d",
                                 i, n, o_cnt[i], mlen[i]);
            end
            n_cmp++;
            if (of !== ef) begin
               n_err++; $display("FAIL rand_flags u%0d cyc%0d: got %b expected %b",
                                 i, n, of, ef);
            end
            if ((mfw[i] == 0) || (mlen[i] > 0)) begin
               n_cmp++;
               if (o_dout[i] !== ((mfw[i] != 0) ? mbuf[i][0] : mdout[i])) begin
                  n_err++; $display("FAIL rand_dout u%0d cyc%0d: got %h expected %h", i, n,
                                    o_dout[i], (mfw[i] != 0) ? mbuf[i][0] : mdout[i]);
               end
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; din = 8'h00; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      test_reset();
      rst = 1'b0;
      test_fill_and_order();
      test_read_latency();
      test_boundary();
      test_flush();
      test_steady_wrap();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_sync_fifo_param
